// File: rtl/rx_sync_pkg.sv
// Shared definitions for the receive-side frame scheduler: state encoding,
// default timing constants and a small window-membership helper.
package rx_sync_pkg;

    localparam int unsigned SCHED_STATE_W = 32'd3;

    typedef enum logic [SCHED_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_TRACK   = 3'd3,
        ST_HOLDOFF = 3'd4
    } sched_state_t;

    localparam int unsigned DEF_SZ_FRAME     = 32'd1000;
    localparam int unsigned DEF_HDR_LEN      = 32'd64;
    localparam int unsigned DEF_PAYLOAD_LEN  = 32'd800;
    localparam int unsigned DEF_ACQ_TIMEOUT  = 32'd50000;
    localparam int unsigned DEF_FILT_RST_LEN = 32'd4;
    localparam int unsigned DEF_HOLDOFF      = 32'd256;

    localparam logic [7:0] SAT8_MAX = 8'hFF;

    // True when an offset lies inside [hdr, hdr+len).
    function automatic logic in_window(input logic [31:0] ofs,
                                       input logic [31:0] hdr,
                                       input logic [31:0] len);
        return (ofs >= hdr) && (ofs < (hdr + len));
    endfunction

endpackage

// File: rtl/sop_frame_sched_if.sv
// Bus bundle between the SOP filter side and the frame scheduler.
// The master drives the filter status and enable; the slave is the scheduler.
interface sop_frame_sched_if;
    import rx_sync_pkg::*;

    logic                     en;
    logic                     found_sync;
    logic                     osop;
    logic                     filt_rst;
    logic                     frame_start;
    logic                     payload_valid;
    logic [15:0]              frame_idx;
    logic [7:0]               lock_loss_cnt;
    logic [7:0]               overrun_cnt;
    logic [SCHED_STATE_W-1:0] sched_state;

    modport master (
        output en, found_sync, osop,
        input  filt_rst, frame_start, payload_valid, frame_idx,
               lock_loss_cnt, overrun_cnt, sched_state
    );

    modport slave (
        input  en, found_sync, osop,
        output filt_rst, frame_start, payload_valid, frame_idx,
               lock_loss_cnt, overrun_cnt, sched_state
    );
endinterface

// File: rtl/sat_cnt8.sv
// Registered 8-bit event counter that sticks at full scale instead of wrapping.
module sat_cnt8
    import rx_sync_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_r;

    // Count increments until full scale; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (inc && (count_r != SAT8_MAX)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/sop_frame_sched.sv
// Frame scheduler: resets the SOP filter, waits for lock, then turns each
// normalized SOP into a frame strobe and a payload window. Lock loss or a
// failed acquisition sends the filter back through a reset pulse.
module sop_frame_sched
    import rx_sync_pkg::*;
#(
    parameter int unsigned SZ_FRAME     = DEF_SZ_FRAME,
    parameter int unsigned HDR_LEN      = DEF_HDR_LEN,
    parameter int unsigned PAYLOAD_LEN  = DEF_PAYLOAD_LEN,
    parameter int unsigned ACQ_TIMEOUT  = DEF_ACQ_TIMEOUT,
    parameter int unsigned FILT_RST_LEN = DEF_FILT_RST_LEN,
    parameter int unsigned HOLDOFF      = DEF_HOLDOFF
)
(
    input  logic clk,
    input  logic rst_n,
    sop_frame_sched_if.slave bus
);

    // Offset counter stops at twice the frame length so a lost SOP stream
    // cannot wrap it back into the payload window.
    localparam int unsigned OFS_SAT = 32'd2 * SZ_FRAME;
    localparam int unsigned OFS_W   = $clog2(OFS_SAT + 32'd1);

    localparam int unsigned TMR_MAX_A = (ACQ_TIMEOUT > HOLDOFF) ? ACQ_TIMEOUT : HOLDOFF;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > FILT_RST_LEN) ? TMR_MAX_A : FILT_RST_LEN;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 32'd1);

    localparam logic [OFS_W-1:0] OFS_SAT_V  = OFS_W'(OFS_SAT);
    localparam logic [TMR_W-1:0] ACQ_LAST   = TMR_W'(ACQ_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] FRST_LAST  = TMR_W'(FILT_RST_LEN - 32'd1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLDOFF - 32'd1);

    if ((HDR_LEN + PAYLOAD_LEN) >= SZ_FRAME) begin : g_bad_frame_layout
        $error("sop_frame_sched: HDR_LEN + PAYLOAD_LEN must be less than SZ_FRAME");
    end
    if ((ACQ_TIMEOUT == 32'd0) || (FILT_RST_LEN == 32'd0) || (HOLDOFF == 32'd0)) begin : g_bad_timers
        $error("sop_frame_sched: ACQ_TIMEOUT, FILT_RST_LEN and HOLDOFF must be non-zero");
    end

    sched_state_t     state_r;
    logic [TMR_W-1:0] timer_r;
    logic [OFS_W-1:0] offset_r;
    logic             filt_rst_r;
    logic             frame_start_r;
    logic             payload_valid_r;
    logic [15:0]      frame_idx_r;

    logic [OFS_W-1:0] offset_inc_s;
    logic             pv_next_s;
    logic             pv_sop_s;
    logic             lock_loss_inc_s;
    logic             overrun_inc_s;

    // Next offset value, window decode and event pulses for the counters.
    always_comb begin
        offset_inc_s    = offset_r;
        pv_next_s       = 1'b0;
        pv_sop_s        = 1'b0;
        lock_loss_inc_s = 1'b0;
        overrun_inc_s   = 1'b0;

        if (offset_r >= OFS_SAT_V) begin
            offset_inc_s = OFS_SAT_V;
        end else begin
            offset_inc_s = offset_r + OFS_W'(1);
        end

        pv_next_s = in_window(32'(offset_inc_s), HDR_LEN, PAYLOAD_LEN);
        pv_sop_s  = in_window(32'd0, HDR_LEN, PAYLOAD_LEN);

        if (bus.en) begin
            case (state_r)
                ST_SEARCH: begin
                    lock_loss_inc_s = !bus.found_sync && (timer_r == ACQ_LAST);
                end
                ST_TRACK: begin
                    lock_loss_inc_s = !bus.found_sync;
                    overrun_inc_s   = bus.found_sync && bus.osop && payload_valid_r;
                end
                default: begin
                    lock_loss_inc_s = 1'b0;
                    overrun_inc_s   = 1'b0;
                end
            endcase
        end else begin
            lock_loss_inc_s = 1'b0;
            overrun_inc_s   = 1'b0;
        end
    end

    // Scheduler state machine with all of its outputs registered alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            timer_r         <= '0;
            offset_r        <= '0;
            filt_rst_r      <= 1'b1;
            frame_start_r   <= 1'b0;
            payload_valid_r <= 1'b0;
            frame_idx_r     <= 16'd0;
        end else if (!bus.en) begin
            state_r         <= ST_IDLE;
            timer_r         <= '0;
            offset_r        <= OFS_SAT_V;
            filt_rst_r      <= 1'b1;
            frame_start_r   <= 1'b0;
            payload_valid_r <= 1'b0;
        end else begin
            frame_start_r   <= 1'b0;
            payload_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_RESET;
                    timer_r    <= '0;
                    filt_rst_r <= 1'b1;
                end
                ST_RESET: begin
                    if (timer_r == FRST_LAST) begin
                        state_r    <= ST_SEARCH;
                        timer_r    <= '0;
                        filt_rst_r <= 1'b0;
                    end else begin
                        timer_r    <= timer_r + TMR_W'(1);
                        filt_rst_r <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    filt_rst_r <= 1'b0;
                    if (bus.found_sync) begin
                        // No frame seen yet: park the offset outside the window.
                        state_r  <= ST_TRACK;
                        timer_r  <= '0;
                        offset_r <= OFS_SAT_V;
                    end else if (timer_r == ACQ_LAST) begin
                        state_r    <= ST_RESET;
                        timer_r    <= '0;
                        filt_rst_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                ST_TRACK: begin
                    filt_rst_r <= 1'b0;
                    if (!bus.found_sync) begin
                        // An osop coinciding with the lock drop is discarded.
                        state_r <= ST_HOLDOFF;
                        timer_r <= '0;
                    end else if (bus.osop) begin
                        frame_start_r   <= 1'b1;
                        frame_idx_r     <= frame_idx_r + 16'd1;
                        offset_r        <= '0;
                        payload_valid_r <= pv_sop_s;
                    end else begin
                        offset_r        <= offset_inc_s;
                        payload_valid_r <= pv_next_s;
                    end
                end
                ST_HOLDOFF: begin
                    filt_rst_r <= 1'b0;
                    if (timer_r == HOLD_LAST) begin
                        state_r    <= ST_RESET;
                        timer_r    <= '0;
                        filt_rst_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    timer_r    <= '0;
                    filt_rst_r <= 1'b1;
                end
            endcase
        end
    end

    sat_cnt8 u_lock_loss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (lock_loss_inc_s),
        .count (bus.lock_loss_cnt)
    );

    sat_cnt8 u_overrun_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (overrun_inc_s),
        .count (bus.overrun_cnt)
    );

    assign bus.sched_state   = state_r;
    assign bus.filt_rst      = filt_rst_r;
    assign bus.frame_start   = frame_start_r;
    assign bus.payload_valid = payload_valid_r;
    assign bus.frame_idx     = frame_idx_r;

endmodule

// File: tb/tb_sop_frame_sched.sv
// Bench for sop_frame_sched: a timestamp-based reference model predicts every
// output each cycle; directed scenarios plus a random phase drive the inputs.
module tb_sop_frame_sched;
    import rx_sync_pkg::*;

    localparam int P_SZ   = 40;
    localparam int P_HDR  = 4;
    localparam int P_PL   = 20;
    localparam int P_ACQ  = 20;
    localparam int P_FRST = 4;
    localparam int P_HOLD = 10;

    logic clk;
    logic rst_n;
    sop_frame_sched_if bus();

    sop_frame_sched #(
        .SZ_FRAME     (P_SZ),
        .HDR_LEN      (P_HDR),
        .PAYLOAD_LEN  (P_PL),
        .ACQ_TIMEOUT  (P_ACQ),
        .FILT_RST_LEN (P_FRST),
        .HOLDOFF      (P_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: phases remembered by entry timestamp, frames by SOP time.
    int           cyc = 0;
    int           t_enter = 0;
    int           t_sop = -1;
    int           m_fidx = 0;
    int           m_ll = 0;
    int           m_ov = 0;
    int           age;
    sched_state_t mst = ST_IDLE;
    bit           mvalid = 1'b0;
    logic         pv_prev;

    function automatic logic exp_pv(input int c);
        int d;
        d = c - t_sop;
        return (mst == ST_TRACK) && (t_sop >= 0) && (d >= P_HDR) && (d < P_HDR + P_PL);
    endfunction

    always @(posedge clk) begin
        pv_prev = exp_pv(cyc);
        cyc = cyc + 1;
        age = cyc - 1 - t_enter;
        if (!rst_n) begin
            mst = ST_IDLE; t_enter = cyc; t_sop = -1;
            m_fidx = 0; m_ll = 0; m_ov = 0; mvalid = 1'b1;
        end else if (!bus.en) begin
            mst = ST_IDLE; t_enter = cyc; t_sop = -1;
        end else begin
            case (mst)
                ST_IDLE: begin mst = ST_RESET; t_enter = cyc; end
                ST_RESET: if (age == P_FRST - 1) begin mst = ST_SEARCH; t_enter = cyc; end
                ST_SEARCH: begin
                    if (bus.found_sync) begin
                        mst = ST_TRACK; t_enter = cyc; t_sop = -1;
                    end else if (age == P_ACQ - 1) begin
                        mst = ST_RESET; t_enter = cyc;
                        if (m_ll < 255) m_ll = m_ll + 1;
                    end
                end
                ST_TRACK: begin
                    if (!bus.found_sync) begin
                        mst = ST_HOLDOFF; t_enter = cyc;
                        if (m_ll < 255) m_ll = m_ll + 1;
                    end else if (bus.osop) begin
                        if (pv_prev && m_ov < 255) m_ov = m_ov + 1;
                        t_sop = cyc;
                        m_fidx = (m_fidx + 1) % 65536;
                    end
                end
                ST_HOLDOFF: if (age == P_HOLD - 1) begin mst = ST_RESET; t_enter = cyc; end
                default: mst = ST_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output plus state run-length bookkeeping.
    logic [37:0] got_v, exp_v;
    int          last_run [8];
    int          run_len = 0;
    logic [2:0]  run_st = 3'd0;

    always @(negedge clk) begin
        if (mvalid) begin
            got_v = {bus.sched_state, bus.filt_rst, bus.frame_start, bus.payload_valid,
                     bus.frame_idx, bus.lock_loss_cnt, bus.overrun_cnt};
            exp_v = {mst, (mst == ST_IDLE) || (mst == ST_RESET),
                     (mst == ST_TRACK) && (t_sop == cyc), exp_pv(cyc),
                     16'(m_fidx), 8'(m_ll), 8'(m_ov)};
            checks = checks + 1;
            if (got_v !== exp_v) begin
                errs = errs + 1;
                $display("FAIL cycle_compare cyc=%0d got=%h exp=%h (state,filt_rst,fs,pv,idx,ll,ov)",
                         cyc, got_v, exp_v);
            end
            if (bus.sched_state == run_st) begin
                run_len = run_len + 1;
            end else begin
                last_run[run_st] = run_len;
                run_st = bus.sched_state;
                run_len = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic f, input logic o);
        bus.en = e;
        bus.found_sync = f;
        bus.osop = o;
        @(posedge clk);
        #1;
    endtask

    int  pv_cnt;
    bit  fs_r;

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.found_sync = 1'b0; bus.osop = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("reset_state", 32'(bus.sched_state), 32'd0);
        chk("reset_filt_rst", 32'(bus.filt_rst), 32'd1);
        chk("reset_counters", {bus.frame_idx, bus.lock_loss_cnt, bus.overrun_cnt}, 32'd0);

        // Acquire: IDLE, 4-cycle filter reset, short search, then lock.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("track_entered", 32'(bus.sched_state), 32'd3);
        chk("filt_rst_pulse_len", 32'(last_run[1]), 32'd4);

        // Nominal frames every SZ_FRAME cycles.
        pv_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            tick(1'b1, 1'b1, 1'b1);
            chk("frame_start_after_osop", 32'(bus.frame_start), 32'd1);
            for (int j = 0; j < P_SZ - 1; j++) begin
                tick(1'b1, 1'b1, 1'b0);
                pv_cnt = pv_cnt + int'(bus.payload_valid);
            end
        end
        chk("frame_idx_after_4", 32'(bus.frame_idx), 32'd4);
        chk("payload_cycles_4_frames", 32'(pv_cnt), 32'd80);

        // Overrun: SOP while the payload window is open.
        tick(1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 10; j++) tick(1'b1, 1'b1, 1'b0);
        chk("pv_open_at_offset10", 32'(bus.payload_valid), 32'd1);
        tick(1'b1, 1'b1, 1'b1);
        chk("overrun_pv_closed", 32'(bus.payload_valid), 32'd0);
        chk("overrun_frame_start", 32'(bus.frame_start), 32'd1);
        chk("overrun_cnt_1", 32'(bus.overrun_cnt), 32'd1);
        chk("frame_idx_6", 32'(bus.frame_idx), 32'd6);

        // Lock drop mid-payload, with an osop in the same cycle.
        for (int j = 0; j < 10; j++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("lockdrop_pv_low", 32'(bus.payload_valid), 32'd0);
        chk("lockdrop_holdoff", 32'(bus.sched_state), 32'd4);
        chk("lockdrop_ll_1", 32'(bus.lock_loss_cnt), 32'd1);
        chk("lockdrop_osop_ignored", 32'(bus.frame_idx), 32'd6);
        for (int j = 0; j < P_HOLD - 1; j++) tick(1'b1, 1'b1, 1'b0);
        chk("holdoff_ignores_sync", 32'(bus.sched_state), 32'd4);
        tick(1'b1, 1'b0, 1'b0);
        chk("holdoff_to_reset", 32'(bus.filt_rst), 32'd1);
        for (int j = 0; j < P_FRST + 1; j++) tick(1'b1, 1'b0, 1'b0);
        chk("holdoff_len", 32'(last_run[4]), 32'd10);
        chk("rearm_pulse_len", 32'(last_run[1]), 32'd4);

        // Disable while tracking: IDLE next cycle, counters kept.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("disable_idle", 32'(bus.sched_state), 32'd0);
        chk("disable_filt_rst", 32'(bus.filt_rst), 32'd1);
        chk("disable_keeps_counts", {bus.frame_idx, bus.lock_loss_cnt, bus.overrun_cnt},
            {16'd7, 8'd1, 8'd1});

        // Repeated acquisition timeouts until the lock-loss counter saturates.
        for (int j = 0; j < 260 * (P_ACQ + P_FRST); j++) tick(1'b1, 1'b0, 1'b0);
        chk("search_len", 32'(last_run[2]), 32'(P_ACQ));
        chk("lock_loss_saturated", 32'(bus.lock_loss_cnt), 32'd255);

        // Random traffic including disables and mid-frame resets.
        fs_r = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 59) == 0) fs_r = ~fs_r;
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick(($urandom_range(0, 49) != 0), fs_r, ($urandom_range(0, 14) == 0));
        end
        rst_n = 1'b1;

        // Frame counter wrap: 65537 frames from reset.
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 65537; j++) tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("frame_idx_wrapped", 32'(bus.frame_idx), 32'd1);
        chk("no_overrun_at_hdr", 32'(bus.overrun_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
